// File: rtl/nl_output_writeback_pkg.sv
// rtl/nl_output_writeback_pkg.sv - shared widths and state type for the nonlinear output writeback stage
package nl_output_writeback_pkg;

    localparam int N_DIM_ARRAY = 4;
    localparam int DATA_WIDTH  = 8;
    localparam int ADDR_WIDTH  = 16;
    localparam int CNT_WIDTH   = 16;
    localparam int FIFO_DEPTH  = 4;
    localparam int WORD_WIDTH  = N_DIM_ARRAY * DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/nl_wb_fifo.sv
// rtl/nl_wb_fifo.sv - small synchronous FIFO buffering result words ahead of the memory port
module nl_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_MAX);
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    // A push into a full FIFO is refused even if a pop frees a slot this cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nl_output_writeback.sv
// rtl/nl_output_writeback.sv - buffers nonlinear results and writes them to activation memory from a base address
module nl_output_writeback
    import nl_output_writeback_pkg::*;
#(
    parameter int P_N_DIM_ARRAY = N_DIM_ARRAY,
    parameter int P_DATA_WIDTH  = DATA_WIDTH,
    parameter int P_ADDR_WIDTH  = ADDR_WIDTH,
    parameter int P_FIFO_DEPTH  = FIFO_DEPTH
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_start,
    input  logic [P_ADDR_WIDTH-1:0]               i_base_addr,
    input  logic [CNT_WIDTH-1:0]                  i_num_words,
    input  logic                                  i_in_valid,
    input  logic [P_N_DIM_ARRAY*P_DATA_WIDTH-1:0] i_in_word,
    output logic                                  o_in_ready,
    output logic                                  o_mem_req,
    input  logic                                  i_mem_gnt,
    output logic                                  o_mem_we,
    output logic [P_ADDR_WIDTH-1:0]               o_mem_addr,
    output logic [P_N_DIM_ARRAY*P_DATA_WIDTH-1:0] o_mem_wdata,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_drop_err
);

    localparam int W_WIDTH = P_N_DIM_ARRAY * P_DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    wb_state_e              r_state;
    wb_state_e              w_next_state;
    logic [P_ADDR_WIDTH-1:0] r_base_addr;
    logic [CNT_WIDTH-1:0]   r_num_words;
    logic [CNT_WIDTH-1:0]   r_acc_cnt;
    logic [CNT_WIDTH-1:0]   r_wr_cnt;
    logic                   r_drop_err;

    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [W_WIDTH-1:0]     w_fifo_head;
    logic                   w_push;
    logic                   w_grant;
    logic                   w_start_ok;
    logic                   w_last_write;

    assign w_start_ok   = i_start && (r_state == ST_IDLE);
    assign w_push       = i_in_valid && o_in_ready;
    assign w_grant      = o_mem_req && i_mem_gnt;
    assign w_last_write = w_grant && ((r_wr_cnt + CNT_ONE) == r_num_words);

    nl_wb_fifo #(
        .DEPTH (P_FIFO_DEPTH),
        .WIDTH (W_WIDTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata (i_in_word),
        .i_pop   (w_grant),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = (i_num_words == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_write) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready = 1'b0;
        o_mem_req  = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            ST_RUN: begin
                o_in_ready = !w_fifo_full && (r_acc_cnt < r_num_words);
                o_mem_req  = !w_fifo_empty;
                o_busy     = 1'b1;
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_mem_we    = o_mem_req;
    assign o_mem_addr  = r_base_addr + P_ADDR_WIDTH'(r_wr_cnt);
    assign o_mem_wdata = w_fifo_head;
    assign o_drop_err  = r_drop_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base_addr <= '0;
            r_num_words <= '0;
            r_acc_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_drop_err  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_base_addr <= i_base_addr;
                r_num_words <= i_num_words;
                r_acc_cnt   <= '0;
                r_wr_cnt    <= '0;
                r_drop_err  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_acc_cnt <= r_acc_cnt + CNT_ONE;
                end
                if (w_grant) begin
                    r_wr_cnt <= r_wr_cnt + CNT_ONE;
                end
            end
            // A word arriving while idle or done is discarded; flag it even on a start cycle.
            if (i_in_valid && (r_state == ST_IDLE || r_state == ST_DONE)) begin
                r_drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nl_output_writeback.sv
// tb/tb_nl_output_writeback.sv - self-checking bench for nl_output_writeback
module tb_nl_output_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] num_words;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_ready;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        drop_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    nl_output_writeback dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_num_words (num_words),
        .i_in_valid  (in_valid),
        .i_in_word   (in_word),
        .o_in_ready  (in_ready),
        .o_mem_req   (mem_req),
        .i_mem_gnt   (mem_gnt),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_drop_err  (drop_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a phase (0 idle, 1 running, 2 done), a queue of buffered words, counts.
    int          m_phase;
    logic [15:0] m_base, m_num, m_acc, m_wr;
    logic [31:0] m_q[$];
    logic        m_drop;

    always @(posedge clk or negedge rst_n) begin
        bit rdy, req;
        if (!rst_n) begin
            m_phase = 0; m_base = 0; m_num = 0; m_acc = 0; m_wr = 0; m_drop = 0;
            m_q.delete();
        end else begin
            rdy = (m_phase == 1) && (m_q.size() < 4) && (m_acc < m_num);
            req = (m_phase == 1) && (m_q.size() > 0);
            if (m_phase == 2) begin
                if (in_valid) m_drop = 1;
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (start) begin
                    m_base = base_addr; m_num = num_words; m_acc = 0; m_wr = 0; m_drop = 0;
                    m_phase = (num_words == 0) ? 2 : 1;
                end
                if (in_valid) m_drop = 1;
            end else begin
                if (req && mem_gnt) begin
                    void'(m_q.pop_front());
                    m_wr++;
                end
                if (in_valid && rdy) begin
                    m_q.push_back(in_word);
                    m_acc++;
                end
                if (req && mem_gnt && m_wr == m_num) m_phase = 2;
            end
        end
    end

    always @(negedge clk) begin
        bit req;
        if (!rst_n) begin
            chk("rst_in_ready", {31'd0, in_ready}, 0);
            chk("rst_mem_req", {31'd0, mem_req}, 0);
            chk("rst_mem_addr", {16'd0, mem_addr}, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_busy_done_err", {29'd0, busy, done, drop_err}, 0);
        end else begin
            req = (m_phase == 1) && (m_q.size() > 0);
            chk("in_ready", {31'd0, in_ready},
                {31'd0, (m_phase == 1) && (m_q.size() < 4) && (m_acc < m_num)});
            chk("mem_req", {31'd0, mem_req}, {31'd0, req});
            chk("mem_we", {31'd0, mem_we}, {31'd0, req});
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, 16'(m_base + m_wr)});
            if (req) chk("mem_wdata", mem_wdata, m_q[0]);
            chk("busy", {31'd0, busy}, {31'd0, m_phase == 1});
            chk("done", {31'd0, done}, {31'd0, m_phase == 2});
            chk("drop_err", {31'd0, drop_err}, {31'd0, m_drop});
        end
    end

    // Log of writes actually issued by the DUT, checked against literal tables.
    logic [15:0] log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_gnt) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] n);
        start = 1; base_addr = b; num_words = n;
        tick();
        start = 0;
    endtask

    task automatic offer(input logic [31:0] w, input int bound, output bit acc);
        in_valid = 1; in_word = w; acc = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1;
            tick();
            if (acc) break;
        end
        in_valid = 0;
    endtask

    task automatic wait_done(input string name, input int bound);
        bit got = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        chk(name, {31'd0, got}, 1);
        tick();
    endtask

    task automatic check_write(input string name, input int idx, input logic [15:0] a, input logic [31:0] d);
        if (idx < log_addr.size()) begin
            chk({name, "_addr"}, {16'd0, log_addr[idx]}, {16'd0, a});
            chk({name, "_data"}, log_data[idx], d);
        end else begin
            chk({name, "_missing"}, 0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w1[4] = '{32'h8107F27F, 32'h00FF0180, 32'h7F7F8080, 32'h12345678};
        logic [31:0] w2[6] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3,
                               32'hD0D1D2D3, 32'hE0E1E2E3, 32'hF0F1F2F3};
        logic [15:0] a4[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        bit acc;
        int n_acc;

        rst_n = 0; start = 0; base_addr = 0; num_words = 0;
        in_valid = 0; in_word = 0; mem_gnt = 0;
        tick(); tick();
        chk("reset_in_ready", {31'd0, in_ready}, 0);
        chk("reset_mem_req", {31'd0, mem_req}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        rst_n = 1;
        tick();

        // 1: zero-wait writes, four back-to-back words
        clear_log();
        mem_gnt = 1;
        do_start(16'h0100, 16'd4);
        for (int i = 0; i < 4; i++) offer(w1[i], 4, acc);
        wait_done("t1_done", 20);
        chk("t1_count", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) check_write("t1", i, 16'h0100 + 16'(i), w1[i]);
        if (log_cyc.size() == 4) chk("t1_consecutive", log_cyc[3] - log_cyc[0], 3);

        // 2: grant held low, FIFO fills, then releases
        clear_log();
        mem_gnt = 0;
        do_start(16'h0200, 16'd6);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    offer(w2[i], 40, acc);
                    chk("t2_accept", {31'd0, acc}, 1);
                end
            end
            begin
                repeat (10) tick();
                chk("t2_stall_ready", {31'd0, in_ready}, 0);
                chk("t2_stall_req", {31'd0, mem_req}, 1);
                chk("t2_stall_addr", {16'd0, mem_addr}, 32'h0200);
                chk("t2_stall_data", mem_wdata, 32'hA0A1A2A3);
                chk("t2_stall_nowrite", log_addr.size(), 0);
                mem_gnt = 1;
            end
        join
        wait_done("t2_done", 40);
        chk("t2_count", log_addr.size(), 6);
        for (int i = 0; i < 6; i++) check_write("t2", i, 16'h0200 + 16'(i), w2[i]);

        // 3: more words offered than programmed
        clear_log();
        mem_gnt = 1;
        n_acc = 0;
        do_start(16'h0300, 16'd3);
        for (int i = 0; i < 3; i++) begin
            offer(w2[i], 4, acc);
            if (acc) n_acc++;
        end
        for (int i = 3; i < 5; i++) begin
            offer(w2[i], 2, acc);
            if (acc) n_acc++;
        end
        chk("t3_accepted", n_acc, 3);
        chk("t3_count", log_addr.size(), 3);
        check_write("t3_last", 2, 16'h0302, 32'hC0C1C2C3);
        tick(); tick();

        // 4: address wrap
        clear_log();
        do_start(16'hFFFE, 16'd4);
        for (int i = 0; i < 4; i++) offer(w1[i], 4, acc);
        wait_done("t4_done", 20);
        chk("t4_count", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) check_write("t4", i, a4[i], w1[i]);

        // 5: drop in idle, start clears it, start during run ignored
        clear_log();
        in_valid = 1; in_word = 32'hDEADBEEF;
        tick();
        in_valid = 0;
        chk("t5_drop_set", {31'd0, drop_err}, 1);
        chk("t5_no_req", {31'd0, mem_req}, 0);
        do_start(16'h0400, 16'd2);
        chk("t5_drop_clear", {31'd0, drop_err}, 0);
        do_start(16'h0500, 16'd9);
        chk("t5_still_busy", {31'd0, busy}, 1);
        offer(32'h11223344, 4, acc);
        offer(32'h55667788, 4, acc);
        wait_done("t5_done", 20);
        chk("t5_count", log_addr.size(), 2);
        check_write("t5_0", 0, 16'h0400, 32'h11223344);
        check_write("t5_1", 1, 16'h0401, 32'h55667788);

        // 6: reset mid-operation with buffered words
        clear_log();
        mem_gnt = 0;
        do_start(16'h0600, 16'd5);
        offer(32'hCAFE0001, 4, acc);
        offer(32'hCAFE0002, 4, acc);
        tick();
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("t6_req_zero", {31'd0, mem_req}, 0);
        chk("t6_addr_zero", {16'd0, mem_addr}, 0);
        chk("t6_data_zero", mem_wdata, 0);
        chk("t6_busy_zero", {31'd0, busy}, 0);
        tick(); tick();
        rst_n = 1;
        tick();
        clear_log();
        mem_gnt = 1;
        do_start(16'h0700, 16'd1);
        offer(32'h0BADF00D, 4, acc);
        wait_done("t6_done", 20);
        chk("t6_count", log_addr.size(), 1);
        check_write("t6_new", 0, 16'h0700, 32'h0BADF00D);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
